kfps2kb_host_sequencer: RTL and testbench

Host-to-device command sequencer for the PS/2 keyboard port. It takes one- or two-byte commands (e.g. 0xED + LED mask, 0xFF reset) and owns the PS/2 lines while it drives them: inhibit, request-to-send, serial shift-out with odd parity, ACK-bit check and 0xFA/0xFE response handling. It sits beside the keyboard receive shift register, consumes that register's byte strobe during response windows, and tells the keycode path which bytes it has claimed.

---
 rtl/kfps2kb_pkg.sv | 34 +++
 rtl/kfps2kb_line_sync.sv | 35 +++
 rtl/kfps2kb_host_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_kfps2kb_host_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kfps2kb_pkg.sv
// kfps2kb_pkg: shared types and constants for the PS/2 host command sequencer.
// Revision: 1.0
`default_nettype none
package kfps2kb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_RESP = 3'd5,
      DONE      = 3'd6,
      ERR       = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_TIMEOUT  = 2'd1,
      ERR_NO_ACK   = 2'd2,
      ERR_RESPONSE = 2'd3
   } err_code_t;

   localparam logic [7:0] PS2_ACK     = 8'hFA;
   localparam logic [7:0] PS2_RESEND  = 8'hFE;
   localparam logic [7:0] PS2_SET_LED = 8'hED;

   // Bit 0 is the start bit, bit 10 the stop bit.
   function automatic logic [10:0] ps2_frame(input logic [7:0] data);
      return {1'b1, ~^data, data, 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/kfps2kb_line_sync.sv
// kfps2kb_line_sync: 2-flop synchronizer for the PS/2 lines plus a registered clock falling-edge pulse.
// Revision: 1.0
`default_nettype none
module kfps2kb_line_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic device_clock,
   input  logic device_data,
   output logic data_sync,
   output logic clock_fall
);

   logic [1:0] clk_ff;
   logic [1:0] dat_ff;
   logic       clk_prev;

   // Idle PS/2 lines are pulled high, so reset the chain to 1 to avoid a false edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_ff     <= 2'b11;
         dat_ff     <= 2'b11;
         clk_prev   <= 1'b1;
         clock_fall <= 1'b0;
      end else begin
         clk_ff     <= {clk_ff[0], device_clock};
         dat_ff     <= {dat_ff[0], device_data};
         clk_prev   <= clk_ff[1];
         clock_fall <= clk_prev & ~clk_ff[1];
      end
   end

   assign data_sync = dat_ff[1];

endmodule
`default_nettype wire

// File: rtl/kfps2kb_host_sequencer.sv
// kfps2kb_host_sequencer: PS/2 host-to-device command sender (inhibit, RTS, shift-out, ACK, response).
// Define KFPS2KB_RETRY_EN to resend a byte after 0xFE up to RETRY_MAX times. Revision: 1.0
`default_nettype none
module kfps2kb_host_sequencer
   import kfps2kb_pkg::*;
#(
   parameter logic [15:0] INHIBIT_CYCLES = 16'd5000,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd750000,
   parameter logic [1:0]  RETRY_MAX      = 2'd2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       device_clock,
   input  logic       device_data,
   output logic       device_clock_oe,
   output logic       device_data_oe,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_byte,
   input  logic       cmd_has_arg,
   input  logic [7:0] cmd_arg,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       rx_claim,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] error_code
);

`ifdef KFPS2KB_RETRY_EN
   localparam logic [1:0] RETRY_LIMIT = RETRY_MAX;
`else
   localparam logic [1:0] RETRY_LIMIT = 2'd0;
   logic unused_retry_max;
   assign unused_retry_max = ^RETRY_MAX;
`endif

   state_t     state, state_n;
   err_code_t  err_q, err_n;
   logic [7:0] cmd_q, arg_q;
   logic       has_arg_q;
   logic       byte_idx, byte_idx_n;
   logic [1:0] retry_cnt, retry_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic [19:0] cnt, cnt_n;
   logic       clock_oe_n, data_oe_n;
   logic       clk_fall, data_sync;
   logic [10:0] frame;
   logic       accept, line_active, timeout, inhibit_end;

   kfps2kb_line_sync u_line_sync (
      .clock        (clock),
      .reset_n      (reset_n),
      .device_clock (device_clock),
      .device_data  (device_data),
      .data_sync    (data_sync),
      .clock_fall   (clk_fall)
   );

   assign frame       = ps2_frame(byte_idx ? arg_q : cmd_q);
   assign accept      = (state == IDLE) && cmd_valid;
   assign line_active = (state == SEND) || (state == ACK) || (state == WAIT_RESP);
   assign timeout     = (cnt >= TIMEOUT_CYCLES - 20'd1);
   assign inhibit_end = (cnt >= {4'd0, INHIBIT_CYCLES - 16'd1});

   assign cmd_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign rx_claim    = (state == WAIT_RESP);
   assign error_code  = err_q;

   always_comb begin
      state_n    = state;
      err_n      = err_q;
      byte_idx_n = byte_idx;
      retry_n    = retry_cnt;
      bit_cnt_n  = bit_cnt;
      clock_oe_n = device_clock_oe;
      data_oe_n  = device_data_oe;
      cnt_n      = cnt + 20'd1;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               byte_idx_n = 1'b0;
               retry_n    = 2'd0;
               err_n      = ERR_NONE;
               clock_oe_n = 1'b1;
               data_oe_n  = 1'b0;
               state_n    = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inhibit_end) begin
               data_oe_n = 1'b1;
               state_n   = RTS;
            end
         end
         RTS: begin
            clock_oe_n = 1'b0;
            data_oe_n  = 1'b1;
            bit_cnt_n  = 4'd1;
            state_n    = SEND;
         end
         SEND: begin
            if (clk_fall) begin
               data_oe_n = ~frame[bit_cnt];
               if (bit_cnt == 4'd10) state_n = ACK;
               else                  bit_cnt_n = bit_cnt + 4'd1;
            end else if (timeout) begin
               err_n      = ERR_TIMEOUT;
               clock_oe_n = 1'b0;
               data_oe_n  = 1'b0;
               state_n    = ERR;
            end
         end
         ACK: begin
            if (clk_fall) begin
               if (!data_sync) begin
                  state_n = WAIT_RESP;
               end else begin
                  err_n      = ERR_NO_ACK;
                  clock_oe_n = 1'b0;
                  data_oe_n  = 1'b0;
                  state_n    = ERR;
               end
            end else if (timeout) begin
               err_n      = ERR_TIMEOUT;
               clock_oe_n = 1'b0;
               data_oe_n  = 1'b0;
               state_n    = ERR;
            end
         end
         WAIT_RESP: begin
            // A response strobe takes priority over a coincident timeout.
            if (rx_valid) begin
               if (rx_byte == PS2_ACK) begin
                  if (!byte_idx && has_arg_q) begin
                     byte_idx_n = 1'b1;
                     retry_n    = 2'd0;
                     clock_oe_n = 1'b1;
                     state_n    = INHIBIT;
                  end else begin
                     state_n = DONE;
                  end
               end else if (rx_byte == PS2_RESEND && retry_cnt != RETRY_LIMIT) begin
                  retry_n    = retry_cnt + 2'd1;
                  clock_oe_n = 1'b1;
                  state_n    = INHIBIT;
               end else begin
                  err_n   = ERR_RESPONSE;
                  state_n = ERR;
               end
            end else if (timeout) begin
               err_n   = ERR_TIMEOUT;
               state_n = ERR;
            end
         end
         DONE:    state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Watchdog/inhibit counter restarts on every state entry and on device clock edges.
      if (state_n != state || state == IDLE || (line_active && clk_fall))
         cnt_n = 20'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         err_q           <= ERR_NONE;
         cmd_q           <= 8'd0;
         arg_q           <= 8'd0;
         has_arg_q       <= 1'b0;
         byte_idx        <= 1'b0;
         retry_cnt       <= 2'd0;
         bit_cnt         <= 4'd0;
         cnt             <= 20'd0;
         device_clock_oe <= 1'b0;
         device_data_oe  <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         state           <= state_n;
         err_q           <= err_n;
         byte_idx        <= byte_idx_n;
         retry_cnt       <= retry_n;
         bit_cnt         <= bit_cnt_n;
         cnt             <= cnt_n;
         device_clock_oe <= clock_oe_n;
         device_data_oe  <= data_oe_n;
         done            <= (state == DONE);
         error           <= (state == ERR);
         if (accept) begin
            cmd_q     <= cmd_byte;
            arg_q     <= cmd_arg;
            has_arg_q <= cmd_has_arg;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kfps2kb_host_sequencer.sv
// tb_kfps2kb_host_sequencer: PS/2 device model plus response-script reference model for the host sequencer.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_kfps2kb_host_sequencer;

   localparam logic [15:0] INH  = 16'd20;
   localparam logic [19:0] TMO  = 20'd400;
   localparam logic [1:0]  RMAX = 2'd2;
   localparam int          HALF = 12;
`ifdef KFPS2KB_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       device_clock, device_data;
   logic       device_clock_oe, device_data_oe;
   logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0;
   logic [7:0] cmd_byte = 8'd0, cmd_arg = 8'd0, rx_byte = 8'd0;
   logic       rx_valid = 1'b0;
   logic       cmd_ready, rx_claim, busy, done, error;
   logic [1:0] error_code;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   logic [7:0] resp [8];
   logic [7:0] exp_bytes [8];
   int         exp_n;
   int         exp_code;

   // Open-collector lines: either side may pull low.
   assign device_clock = dev_clk & ~device_clock_oe;
   assign device_data  = dev_data & ~device_data_oe;

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
   end

   kfps2kb_host_sequencer #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .RETRY_MAX      (RMAX)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .device_clock    (device_clock),
      .device_data     (device_data),
      .device_clock_oe (device_clock_oe),
      .device_data_oe  (device_data_oe),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_byte        (cmd_byte),
      .cmd_has_arg     (cmd_has_arg),
      .cmd_arg         (cmd_arg),
      .rx_byte         (rx_byte),
      .rx_valid        (rx_valid),
      .rx_claim        (rx_claim),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .error_code      (error_code)
   );

   // Walk the response script the way the protocol describes it: one response per frame sent.
   task automatic model_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a);
      int idx = 0;
      int tries = 0;
      int r = 0;
      exp_n = 0;
      exp_code = -1;
      while (exp_code < 0 && r < 8) begin
         exp_bytes[exp_n] = (idx == 0) ? c : a;
         exp_n++;
         if (resp[r] == 8'hFA) begin
            if (idx == 0 && ha) begin
               idx = 1;
               tries = 0;
            end else begin
               exp_code = 0;
            end
         end else if (resp[r] == 8'hFE && RETRY_ON && tries < int'(RMAX)) begin
            tries++;
         end else begin
            exp_code = 3;
         end
         r++;
      end
   endtask

   // Device clocks out `falls` falling edges, sampling the host bit before each one; fall 11 carries the ACK.
   task automatic device_frame(input int falls, input bit ack_ok, output logic [10:0] bits);
      bits = '1;
      repeat (5) @(negedge clock);
      for (int k = 1; k <= falls; k++) begin
         bits[k-1] = device_data;
         if (k == 11) begin
            dev_data = ack_ok ? 1'b0 : 1'b1;
            repeat (3) @(negedge clock);
         end
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clock);
         if (k == 11) dev_data = 1'b1;
      end
   endtask

   task automatic run_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a,
                          input int falls, input bit ack_ok, input int want_code, input string name);
      int d0 = done_cnt;
      int e0 = err_cnt;
      int got = 0;
      int r = 0;
      int w;
      bit ending = 1'b0;
      logic [10:0] bits;
      logic [7:0] gb [8];
      @(negedge clock);
      cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      checks++;
      if (device_clock_oe !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: clock_oe=%b busy=%b, required 1 1", name, device_clock_oe, busy);
      end
      while (!ending) begin
         w = 0;
         while (!(device_data === 1'b0 && device_clock === 1'b1) && done_cnt == d0 && err_cnt == e0 && w < 3000) begin
            @(negedge clock);
            w++;
         end
         if (done_cnt != d0 || err_cnt != e0) begin
            ending = 1'b1;
         end else if (w >= 3000) begin
            checks++; errors++;
            $display("FAIL %s rts_wait: no request-to-send or completion within 3000 cycles", name);
            ending = 1'b1;
         end else begin
            device_frame(falls, ack_ok, bits);
            if (got < 8) gb[got] = bits[8:1];
            got++;
            if (falls == 11) begin
               checks++;
               if (bits[0] !== 1'b0 || bits[10] !== 1'b1 || bits[9] !== ~^bits[8:1]) begin
                  errors++;
                  $display("FAIL %s frame_format: bits=%b, required start 0, odd parity, stop 1", name, bits);
               end
            end
            if (falls < 11 || !ack_ok) begin
               w = 0;
               while (done_cnt == d0 && err_cnt == e0 && w < 3000) begin
                  @(negedge clock);
                  w++;
               end
               if (w >= 3000) begin
                  checks++; errors++;
                  $display("FAIL %s end_wait: no done/error within 3000 cycles", name);
               end
               ending = 1'b1;
            end else begin
               repeat (6) @(negedge clock);
               checks++;
               if (rx_claim !== 1'b1) begin
                  errors++;
                  $display("FAIL %s rx_claim_window: rx_claim=%b, required 1", name, rx_claim);
               end
               rx_byte = resp[r];
               rx_valid = 1'b1;
               if (r < 7) r++;
               @(negedge clock);
               rx_valid = 1'b0;
            end
         end
      end
      repeat (12) @(negedge clock);
      if (falls == 11) begin
         checks++;
         if (got != exp_n) begin
            errors++;
            $display("FAIL %s frame_count: got %0d frames, required %0d", name, got, exp_n);
         end
         for (int i = 0; i < got && i < exp_n && i < 8; i++) begin
            checks++;
            if (gb[i] !== exp_bytes[i]) begin
               errors++;
               $display("FAIL %s frame_byte[%0d]: got %h, required %h", name, i, gb[i], exp_bytes[i]);
            end
         end
      end
      checks++;
      if ((done_cnt - d0) != ((want_code == 0) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d, required %0d", name, done_cnt - d0, (want_code == 0) ? 1 : 0);
      end
      checks++;
      if ((err_cnt - e0) != ((want_code == 0) ? 0 : 1)) begin
         errors++;
         $display("FAIL %s error_pulses: got %0d, required %0d", name, err_cnt - e0, (want_code == 0) ? 0 : 1);
      end
      checks++;
      if (error_code !== want_code[1:0]) begin
         errors++;
         $display("FAIL %s error_code: got %0d, required %0d", name, error_code, want_code);
      end
      checks++;
      if (device_clock_oe !== 1'b0 || device_data_oe !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_after: clock_oe=%b data_oe=%b busy=%b ready=%b, required 0 0 0 1",
                  name, device_clock_oe, device_data_oe, busy, cmd_ready);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rx_claim !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b busy=%b claim=%b, required 1 0 0", cmd_ready, busy, rx_claim);
      end
      checks++;
      if (done !== 1'b0 || error !== 1'b0 || error_code !== 2'd0) begin
         errors++;
         $display("FAIL reset_status: done=%b error=%b code=%0d, required 0 0 0", done, error, error_code);
      end
      checks++;
      if (device_clock_oe !== 1'b0 || device_data_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_lines: clock_oe=%b data_oe=%b, required 0 0", device_clock_oe, device_data_oe);
      end
   endtask

   task automatic test_single_ff;
      resp[0] = 8'hFA;
      for (int i = 1; i < 8; i++) resp[i] = 8'hFA;
      model_cmd(8'hFF, 1'b0, 8'h00);
      run_cmd(8'hFF, 1'b0, 8'h00, 11, 1'b1, exp_code, "single_ff");
   endtask

   task automatic test_two_byte_led;
      for (int i = 0; i < 8; i++) resp[i] = 8'hFA;
      model_cmd(8'hED, 1'b1, 8'h07);
      run_cmd(8'hED, 1'b1, 8'h07, 11, 1'b1, exp_code, "set_led");
   endtask

   task automatic test_resend;
      resp[0] = 8'hFE;
      for (int i = 1; i < 8; i++) resp[i] = 8'hFA;
      model_cmd(8'hF4, 1'b0, 8'h00);
      run_cmd(8'hF4, 1'b0, 8'h00, 11, 1'b1, exp_code, "resend_once");
      for (int i = 0; i < 8; i++) resp[i] = 8'hFE;
      model_cmd(8'hF2, 1'b0, 8'h00);
      run_cmd(8'hF2, 1'b0, 8'h00, 11, 1'b1, exp_code, "resend_exhaust");
   endtask

   task automatic test_random;
      for (int n = 0; n < 8; n++) begin
         logic [7:0] c, a;
         bit ha;
         c  = 8'($urandom);
         a  = 8'($urandom);
         ha = 1'($urandom);
         for (int i = 0; i < 8; i++) begin
            int p;
            p = $urandom_range(0, 9);
            if (p < 6)      resp[i] = 8'hFA;
            else if (p < 9) resp[i] = 8'hFE;
            else begin
               resp[i] = 8'($urandom);
               while (resp[i] == 8'hFA || resp[i] == 8'hFE) resp[i] = 8'($urandom);
            end
         end
         model_cmd(c, ha, a);
         run_cmd(c, ha, a, 11, 1'b1, exp_code, "random");
      end
   endtask

   task automatic test_timeout;
      run_cmd(8'hF0, 1'b0, 8'h00, 4, 1'b1, 1, "timeout");
   endtask

   task automatic test_no_ack;
      exp_n = 1;
      exp_bytes[0] = 8'hF5;
      run_cmd(8'hF5, 1'b0, 8'h00, 11, 1'b0, 2, "no_ack");
   endtask

   task automatic test_reset_in_send;
      int w = 0;
      int d0 = done_cnt;
      @(negedge clock);
      cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      while (!(device_data === 1'b0 && device_clock === 1'b1) && w < 3000) begin
         @(negedge clock);
         w++;
      end
      repeat (5) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clock);
      end
      checks++;
      if (device_data_oe !== 1'b1 || device_clock_oe !== 1'b0) begin
         errors++;
         $display("FAIL send_lines: data_oe=%b clock_oe=%b, required 1 0", device_data_oe, device_clock_oe);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (device_data_oe !== 1'b0 || device_clock_oe !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_lines: data_oe=%b clock_oe=%b, required 0 0", device_data_oe, device_clock_oe);
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready=%b busy=%b, required 1 0", cmd_ready, busy);
      end
      rx_byte = 8'hFA;
      rx_valid = 1'b1;
      #1;
      checks++;
      if (rx_claim !== 1'b0) begin
         errors++;
         $display("FAIL idle_rx_claim: rx_claim=%b, required 0", rx_claim);
      end
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_rx_ignored: done pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_ff();
      test_two_byte_led();
      test_resend();
      test_random();
      test_timeout();
      test_no_ack();
      test_reset_in_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish within 3 ms");
      $fatal(1);
   end

endmodule
`default_nettype wire
